prbs_checker: RTL

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/galoi_pkg.sv | 35 +++
 rtl/prbs_checker.sv | 131 +++++++++++++
 2 files changed

// File: rtl/galoi_pkg.sv
// galoi_pkg -- shared definitions for the 16-bit Galois PRBS checker.
//   state_t      : checker synchronisation states (SEED, HUNT, LOCKED)
//   SEED_WORD    : canonical non-zero starting word of the sequence
//   galois_step  : one advance of the 16-bit Galois LFSR
//   sat_inc16    : 16-bit increment that sticks at all-ones
package galoi_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [15:0] SEED_WORD = 16'h0400;

  // Feedback is taken from bit 1; bit 0 of the current word never feeds
  // the next word.
  function automatic logic [15:0] galois_step(input logic [15:0] q);
    logic [15:0] n;
    n[15]   = q[1];
    n[14]   = q[15] ^ q[1];
    n[13:5] = q[14:6];
    n[4]    = q[5] ^ q[1];
    n[3]    = q[4];
    n[2]    = q[3] ^ q[1];
    n[1]    = q[2];
    n[0]    = q[1];
    return n;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == '1) ? x : x + 16'd1;
  endfunction

endpackage

// File: rtl/prbs_checker.sv
// prbs_checker -- synchronises to a received 16-bit Galois PRBS stream and
// counts word errors once locked.
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_data carries a word this cycle
//   in_data   : received 16-bit LFSR word
//   clr_cnt   : synchronous clear of err_cnt / word_cnt
//   locked    : registered, high while synchronised
//   err_pulse : one-cycle flag for a mismatch counted while locked
//   err_cnt   : saturating count of errored words
//   word_cnt  : saturating count of words checked while locked
module prbs_checker
  import galoi_pkg::*;
#(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned LOSS_N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [15:0] word_cnt
);

  localparam logic [15:0] LOCK_LIM = 16'(LOCK_N);
  localparam logic [15:0] LOSS_LIM = 16'(LOSS_N);

  state_t      state, state_n;
  logic [15:0] pred, pred_n;
  logic [15:0] match_cnt, match_n;
  logic [15:0] miss_cnt, miss_n;
  logic        pulse_n;
  logic [15:0] err_n, word_n;
  logic        hit;
  logic        nonzero;

  assign hit     = (in_data == pred);
  assign nonzero = (in_data != '0);

  always_comb begin
    state_n = state;
    pred_n  = pred;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    pulse_n = 1'b0;
    err_n   = err_cnt;
    word_n  = word_cnt;

    if (in_valid) begin
      unique case (state)
        SEED: begin
          if (nonzero) begin
            pred_n  = galois_step(in_data);
            match_n = '0;
            state_n = HUNT;
          end
        end

        HUNT: begin
          if (hit) begin
            match_n = match_cnt + 16'd1;
            pred_n  = galois_step(pred);
            if (match_n >= LOCK_LIM) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else if (nonzero) begin
            // A failed prediction restarts hunting from this word.
            pred_n  = galois_step(in_data);
            match_n = '0;
          end else begin
            match_n = '0;
            state_n = SEED;
          end
        end

        LOCKED: begin
          // Free-run the prediction so an isolated bit error is not
          // carried into later comparisons.
          pred_n = galois_step(pred);
          word_n = sat_inc16(word_cnt);
          if (hit) begin
            miss_n = '0;
          end else begin
            pulse_n = 1'b1;
            err_n   = sat_inc16(err_cnt);
            miss_n  = miss_cnt + 16'd1;
            if (miss_n >= LOSS_LIM) begin
              state_n = SEED;
              miss_n  = '0;
            end
          end
        end

        default: state_n = SEED;
      endcase
    end

    if (clr_cnt) begin
      err_n  = '0;
      word_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      word_cnt  <= '0;
    end else begin
      state     <= state_n;
      pred      <= pred_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      locked    <= (state_n == LOCKED);
      err_pulse <= pulse_n;
      err_cnt   <= err_n;
      word_cnt  <= word_n;
    end
  end

endmodule
